// File: rtl/deser_pkg.sv
// rtl/deser_pkg.sv - shared types for the lane-arbitrated deserializer
package deser_pkg;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam int NUM_LANES_DEFAULT = 4;

  typedef logic [$clog2(NUM_LANES_DEFAULT)-1:0] lane_idx_t;

endpackage

// File: rtl/deserializer_rst.sv
// rtl/deserializer_rst.sv - bit-serial to word deserializer with synchronous reset
module deserializer_rst #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wen,
  input  logic                  i_data,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  logic [DATA_WIDTH-1:0] shift;
  logic [CNT_W-1:0]      cnt;
  logic                  last;

  assign last = i_wen && (cnt == CNT_W'(DATA_WIDTH - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shift   <= '0;
      cnt     <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= last;
      if (i_wen) begin
        shift <= {i_data, shift[DATA_WIDTH-1:1]};
        cnt   <= last ? '0 : cnt + 1'b1;
      end
    end
  end

  // Output word is not reset so it holds across aborts and core resets
  always_ff @(posedge i_clk) begin
    if (last) begin
      o_data <= {i_data, shift[DATA_WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick, search starts just above the pointer
module rr_arbiter #(
  parameter int NUM_LANES = 4
) (
  input  logic [NUM_LANES-1:0]         i_req,
  input  logic [$clog2(NUM_LANES)-1:0] i_ptr,
  output logic [NUM_LANES-1:0]         o_grant,
  output logic [$clog2(NUM_LANES)-1:0] o_idx,
  output logic                         o_any
);

  localparam int IDX_W = $clog2(NUM_LANES);

  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = |i_req;
    found   = 1'b0;
    cand    = '0;
    // k runs to NUM_LANES so the pointer lane itself is considered last
    for (int k = 1; k <= NUM_LANES; k++) begin
      cand = IDX_W'((int'(i_ptr) + k) % NUM_LANES);
      if (!found && i_req[cand]) begin
        found         = 1'b1;
        o_grant[cand] = 1'b1;
        o_idx         = cand;
      end
    end
  end

endmodule

// File: rtl/deserializer_lane_arbiter.sv
// rtl/deserializer_lane_arbiter.sv - shares one deserializer between serial lanes, word-granular round-robin
module deserializer_lane_arbiter
  import deser_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_LANES  = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NUM_LANES-1:0]         i_req,
  input  logic [NUM_LANES-1:0]         i_wen,
  input  logic [NUM_LANES-1:0]         i_data,
  output logic [NUM_LANES-1:0]         o_grant,
  output logic [DATA_WIDTH-1:0]        o_data,
  output logic                         o_valid,
  output logic [$clog2(NUM_LANES)-1:0] o_src,
  output logic                         o_abort,
  output logic                         o_busy
);

  localparam int IDX_W  = $clog2(NUM_LANES);
  localparam int BIT_W  = $clog2(DATA_WIDTH + 1);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  state_t            state;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  owner;
  logic [BIT_W-1:0]  bit_cnt;
  logic [IDLE_W-1:0] idle_cnt;

  logic [NUM_LANES-1:0] pick;
  logic [IDX_W-1:0]     pick_idx;
  logic                 any_req;

  logic own_wen;
  logic own_data;
  logic last_bit;
  logic do_abort;
  logic core_rst;

  rr_arbiter #(
    .NUM_LANES(NUM_LANES)
  ) u_arb (
    .i_req  (i_req),
    .i_ptr  (ptr),
    .o_grant(pick),
    .o_idx  (pick_idx),
    .o_any  (any_req)
  );

  always_comb begin
    own_wen  = (state == GRANT) && i_wen[owner];
    own_data = i_data[owner];
    last_bit = own_wen && (bit_cnt == BIT_W'(DATA_WIDTH - 1));
    // Abort only on a strobe-less cycle, so a bit arriving with a request drop is still taken
    do_abort = (state == GRANT) && !i_wen[owner] &&
               (!i_req[owner] || (idle_cnt == IDLE_W'(TIMEOUT - 1)));
  end

  // o_abort doubles as the registered abort that clears the core counter
  assign core_rst = i_rst | o_abort;
  assign o_busy   = (state == GRANT);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      o_grant  <= '0;
      o_src    <= '0;
      o_abort  <= 1'b0;
      ptr      <= IDX_W'(NUM_LANES - 1);
      owner    <= '0;
      bit_cnt  <= '0;
      idle_cnt <= '0;
    end else begin
      o_abort <= 1'b0;
      case (state)
        IDLE: begin
          bit_cnt  <= '0;
          idle_cnt <= '0;
          if (any_req) begin
            o_grant <= pick;
            owner   <= pick_idx;
            ptr     <= pick_idx;
            state   <= GRANT;
          end
        end
        GRANT: begin
          if (last_bit) begin
            o_src    <= owner;
            o_grant  <= '0;
            bit_cnt  <= '0;
            idle_cnt <= '0;
            state    <= IDLE;
          end else if (own_wen) begin
            bit_cnt  <= bit_cnt + 1'b1;
            idle_cnt <= '0;
          end else if (do_abort) begin
            o_abort  <= 1'b1;
            o_grant  <= '0;
            bit_cnt  <= '0;
            idle_cnt <= '0;
            state    <= IDLE;
          end else if (idle_cnt != IDLE_W'(TIMEOUT)) begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  deserializer_rst #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_core (
    .i_clk  (i_clk),
    .i_rst  (core_rst),
    .i_wen  (own_wen),
    .i_data (own_data),
    .o_data (o_data),
    .o_valid(o_valid)
  );

endmodule

// File: doc/deserializer_lane_arbiter.md
Name: deserializer_lane_arbiter

Overview:
Shares one 8-bit bit-serial deserializer datapath (deserializer_rst) between NUM_LANES serial requesters. Grants one lane at a time for a whole word, round-robin. Muxes the granted lane's write-enable and data into the deserializer, and tags each completed word with its source lane. Aborts the word if the owner withdraws its request or stalls past a timeout. Sits between the serial front-end lanes and the word-level consumer.

Parameters:
DATA_WIDTH, 8, bits per word; must be >= 2.
NUM_LANES, 4, number of serial requesters; must be >= 2.
TIMEOUT, 16, max consecutive cycles without i_wen from the owner before abort; must be >= 1.

Ports:
i_clk  in  1  clock
i_rst  in  1  reset
i_req  in  NUM_LANES  per-lane ownership request
i_wen  in  NUM_LANES  per-lane bit strobe; honoured only for the granted lane
i_data  in  NUM_LANES  per-lane serial bit
o_grant  out  NUM_LANES  one-hot owner; all zero when idle
o_data  out  DATA_WIDTH  assembled word; first accepted bit lands in bit 0
o_valid  out  1  one-cycle pulse, o_data/o_src valid
o_src  out  $clog2(NUM_LANES)  lane index of the word on o_data
o_abort  out  1  one-cycle pulse, word discarded
o_busy  out  1  high while in GRANT

Behaviour:
- Reset is synchronous and active-high on i_rst; clock is i_clk.
- Reset values: o_grant=0, o_valid=0, o_abort=0, o_busy=0, o_src=0. Round-robin pointer=NUM_LANES-1, so lane 0 wins first. Bit counter=0, idle counter=0. Reset also resets the deserializer.
- FSM states: IDLE, GRANT.
- IDLE:
  - If any i_req is high, pick the first requesting lane searching from pointer+1 upward (modulo NUM_LANES).
  - Register it into o_grant and go to GRANT. o_grant is visible the next cycle.
  - Pointer updates to the winner at grant time.
- GRANT, owner g:
  - The deserializer sees wen = i_wen[g] and data = i_data[g]. All other lanes' i_wen/i_data are ignored.
  - Each accepted bit increments the bit counter and clears the idle counter.
  - A cycle without i_wen[g] increments the idle counter.
- Completion: the DATA_WIDTH-th accepted bit at cycle t gives:
  - o_valid=1, o_src=g and o_data = full word at t+1;
  - o_grant=0 and state=IDLE at t+1;
  - earliest next grant at t+2.
  - The owner must not assume ownership persists. Holding i_req high simply re-arbitrates against the other lanes.
- Abort, checked in GRANT, is triggered when either holds:
  - i_req[g]=0 in any cycle with i_wen[g]=0;
  - the idle counter reaches TIMEOUT.
  On abort:
  - o_abort pulses the next cycle and o_grant clears;
  - the deserializer receives a synchronous reset (core reset = i_rst | abort_r), so its counter returns to 0;
  - the partial word is discarded, no o_valid;
  - state goes to IDLE.
- Simultaneous events:
  - i_req[g] drop together with i_wen[g]=1 on the final bit counts as completion, not abort.
  - A drop with i_wen[g]=1 on a non-final bit accepts that bit, then aborts on the next cycle if i_req is still low.
- o_valid and o_abort are never high together. o_data holds its value between pulses and is not cleared on abort.
- Width rules:
  - bit counter: $clog2(DATA_WIDTH+1) bits, wraps to 0 at completion;
  - idle counter: $clog2(TIMEOUT+1) bits, saturating.
- Reset mid-word: immediate return to reset values; no o_valid or o_abort is generated.

Decomposition:
- Shared package deser_pkg holds the FSM state enum (IDLE, GRANT) and a lane_idx_t typedef sized $clog2(NUM_LANES).
- Sub-module rr_arbiter is natural: combinational one-hot pick given i_req and pointer, parameterised by NUM_LANES. It is reusable by other shared resources.
- deserializer_rst is instantiated unchanged as the datapath.

Test Plan:
- Single lane: i_req=4'b0010, lane 1 sends 8 consecutive bits of 0xA5 LSB-first. Expect o_grant=4'b0010 one cycle after the request, o_valid one cycle after the 8th bit, o_data=0xA5, o_src=1, o_grant=0 in that same cycle.
- Round-robin: all four lanes request continuously, each sending a word equal to 0x10+lane. Expect grants in order 0,1,2,3,0 and o_src sequence 0,1,2,3, with no duplicate or lost words.
- Gapped strobes plus foreign noise: lane 2 sends 0x3C with one idle cycle between bits while lanes 0/1/3 toggle i_wen/i_data. Expect o_data=0x3C, o_src=2, and no effect from the other lanes.
- Request withdrawal: lane 0 sends 3 bits, then drops i_req. Expect o_abort pulse, no o_valid, next grant to lane 1. Lane 0's next full word 0xFF is then assembled correctly, proving the core counter was cleared.
- Timeout: lane 3 sends 2 bits, then goes silent with i_req high. Expect o_abort exactly TIMEOUT=16 cycles after the last bit, +1 cycle registration, and o_grant cleared.
- Reset mid-word: assert i_rst after 5 bits of lane 1. Expect all outputs at reset values and no o_valid/o_abort. With all lanes requesting afterwards, lane 0 wins first.
